alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
Parametrised, registered successor to the team's 4-bit combinational ALU. It keeps the original opcodes for ADD, SUB, AND, OR and NOT, and adds XOR, shifts and an iterative multiply. Operands enter through a valid/ready handshake and results leave, with a flag set, through a registered valid/ready output. It sits between an operand-issue stage and a result-writeback stage.

Parameters:
WIDTH, 8, operand/result width; power of 2, >= 4.
SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept operands
a  in  WIDTH  operand A
b  in  WIDTH  operand B (shift amount = b[SHW-1:0])
op  in  4  opcode
out_valid  out  1  result register valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  result
carry  out  1  carry/borrow/shifted-out bit/multiply high-half nonzero
overflow  out  1  signed overflow
zero  out  1  result == 0
negative  out  1  result[WIDTH-1]
illegal  out  1  opcode was undefined

Behaviour:
- Opcodes: ADD=0000, SUB=0001, AND=0010, OR=0011, NOT=0100 (~a), XOR=0101, SHL=0110, SHR=0111 (logical), SRA=1000, MUL=1001. Codes 1010-1111 are illegal.
- Reset: while rst=1, at the clock edge, state=IDLE, out_valid=0, result=0, all flags=0, illegal=0. in_ready=0 combinationally while rst=1. A rst during MUL aborts the operation; no result is emitted.
- States: IDLE, MUL.
- Accept: accepted on a rising edge where in_valid && in_ready.
- in_ready = !rst && state==IDLE && (!out_valid || out_ready). Output draining and a new accept can happen on the same edge, giving throughput of 1/cycle for non-MUL ops.
- Non-MUL ops: result and flags are registered on the accept edge. out_valid is high in the next cycle (latency 1).
- MUL: the accept edge latches a, b, clears the WIDTH*2 accumulator and sets cnt=0; state goes to MUL.
  - Each edge in MUL adds (b bit cnt) ? a<<cnt to the accumulator, then cnt++.
  - On the edge with cnt==WIDTH-1: write result = acc[WIDTH-1:0], carry = overflow = |acc[2W-1:W] (unsigned); out_valid=1; state goes to IDLE.
  - out_valid rises WIDTH cycles after the accept cycle. in_ready=0 throughout MUL.
- Output hold: while out_valid && !out_ready, result, flags and illegal are stable. out_valid clears on the edge where out_ready=1, unless a new accept loads the register on that same edge.
- Flags:
  - ADD: {carry,result} = a+b (WIDTH+1 bits); overflow = signs of a and b equal and result sign differs.
  - SUB: result = a-b mod 2^WIDTH; carry = 1 iff a<b unsigned (borrow); overflow = signs of a and b differ and result sign differs from a.
  - AND/OR/NOT/XOR: carry=0, overflow=0.
  - SHL/SHR/SRA: carry = last bit shifted out (0 if shamt=0); overflow=0. SRA fills with a[WIDTH-1].
  - All ops: zero=(result==0); negative=result[WIDTH-1].
- Illegal op: result=0, zero=1, illegal=1, other flags 0; latency 1.

Decomposition:
- Shared package alu_pkg: opcode localparams (or a 4-bit enum alu_op_t), state enum alu_state_t {IDLE, MUL}.
- One natural sub-module, alu_pipe_mul: a shift-add multiplier with start/done that owns the accumulator and counter. The top keeps the handshake, the combinational single-cycle datapath and the output register.

Test Plan:
All scenarios use WIDTH=8.
- ADD a=0xF0 b=0x20, out_ready=1 -> next cycle out_valid=1, result=0x10, carry=1, overflow=0, zero=0. ADD 0x7F+0x01 -> 0x80, overflow=1, negative=1.
- SUB a=0x03 b=0x05 -> result=0xFE, carry=1, negative=1, overflow=0. SUB 0x80-0x01 -> 0x7F, overflow=1.
- SHR a=0x81 b=1 -> 0x40, carry=1. SRA a=0x81 b=1 -> 0xC0, carry=1. SHL a=0x81 b=0 -> 0x81, carry=0.
- MUL 0x0F*0x11 -> out_valid exactly 8 cycles after accept, result=0xFF, carry=0. MUL 0x10*0x10 -> result=0x00, carry=1, overflow=1, zero=1. in_ready=0 throughout.
- Backpressure: hold out_ready=0 after an ADD -> result/flags stable, in_ready=0. Raise out_ready with in_valid=1 -> drain and accept on the same edge. Back-to-back ops give 1 result/cycle. op=1100 -> illegal=1, result=0, zero=1.
- Assert rst for one cycle at MUL iteration 3 -> next cycle out_valid=0, in_ready=1 after rst falls, no stale result ever appears. A following ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for the pipelined ALU and its multiplier.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_AND = 4'b0010,
    OP_OR  = 4'b0011,
    OP_NOT = 4'b0100,
    OP_XOR = 4'b0101,
    OP_SHL = 4'b0110,
    OP_SHR = 4'b0111,
    OP_SRA = 4'b1000,
    OP_MUL = 4'b1001
  } alu_op_t;

  typedef enum logic {
    IDLE,
    MUL
  } alu_state_t;

endpackage

// File: rtl/alu_pipe_if.sv
// Operand-in / result-out handshake bundle between issue, ALU and writeback stages.
interface alu_pipe_if #(parameter int WIDTH = 8);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;
  logic             zero;
  logic             negative;
  logic             illegal;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, carry, overflow, zero, negative, illegal
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, carry, overflow, zero, negative, illegal
  );

endinterface

// File: rtl/alu_pipe_mul.sv
// Iterative shift-add multiplier: one partial product per clock, WIDTH clocks per operation.
module alu_pipe_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               run,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] product
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]     cnt_q, cnt_d;

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (start) begin
      a_d   = a;
      b_d   = b;
      acc_d = '0;
      cnt_d = '0;
    end else if (run) begin
      acc_d = acc_q + (b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0);
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  // The final partial product is folded in on the same edge the top captures it.
  assign last    = run && (cnt_q == CNT_LAST);
  assign product = acc_d;

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready in and out; single-cycle ops have latency 1, MUL takes WIDTH cycles.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic       clk,
  input logic       rst,
  alu_pipe_if.slave io
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_t state_q, state_d;

  logic [WIDTH-1:0] result_q, result_d;
  logic             out_valid_q, out_valid_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;
  logic             negative_q, negative_d;
  logic             illegal_q, illegal_d;

  logic               accept;
  logic               mul_start;
  logic               mul_last;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             alu_ill;
  logic [SHW-1:0]   shamt;

  assign shamt       = io.b[SHW-1:0];
  assign io.in_ready = !rst && (state_q == IDLE) && (!out_valid_q || io.out_ready);
  assign accept      = io.in_valid && io.in_ready;
  assign mul_start   = accept && (io.op == OP_MUL);

  alu_pipe_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .run     (state_q == MUL),
    .a       (io.a),
    .b       (io.b),
    .last    (mul_last),
    .product (mul_product)
  );

  // Shifts go through a one-bit-wider word so the last bit shifted out lands in the carry slot.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (io.op)
      OP_ADD: begin
        {alu_c, alu_res} = {1'b0, io.a} + {1'b0, io.b};
        alu_v = (io.a[WIDTH-1] == io.b[WIDTH-1]) && (alu_res[WIDTH-1] != io.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = io.a - io.b;
        alu_c   = io.a < io.b;
        alu_v   = (io.a[WIDTH-1] != io.b[WIDTH-1]) && (alu_res[WIDTH-1] != io.a[WIDTH-1]);
      end
      OP_AND: alu_res = io.a & io.b;
      OP_OR:  alu_res = io.a | io.b;
      OP_NOT: alu_res = ~io.a;
      OP_XOR: alu_res = io.a ^ io.b;
      OP_SHL: {alu_c, alu_res} = {1'b0, io.a} << shamt;
      OP_SHR: {alu_res, alu_c} = {io.a, 1'b0} >> shamt;
      OP_SRA: {alu_res, alu_c} = $signed({io.a, 1'b0}) >>> shamt;
      OP_MUL: alu_ill = 1'b0;
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    negative_d  = negative_q;
    illegal_d   = illegal_q;

    if (out_valid_q && io.out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (io.op == OP_MUL) begin
            state_d = MUL;
          end else begin
            result_d    = alu_res;
            carry_d     = alu_c;
            overflow_d  = alu_v;
            illegal_d   = alu_ill;
            zero_d      = (alu_res == '0);
            negative_d  = alu_res[WIDTH-1];
            out_valid_d = 1'b1;
          end
        end
      end
      MUL: begin
        if (mul_last) begin
          state_d     = IDLE;
          result_d    = mul_product[WIDTH-1:0];
          carry_d     = |mul_product[2*WIDTH-1:WIDTH];
          overflow_d  = |mul_product[2*WIDTH-1:WIDTH];
          illegal_d   = 1'b0;
          zero_d      = (mul_product[WIDTH-1:0] == '0);
          negative_d  = mul_product[WIDTH-1];
          out_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
      negative_q  <= negative_d;
      illegal_q   <= illegal_d;
    end
  end

  assign io.out_valid = out_valid_q;
  assign io.result    = result_q;
  assign io.carry     = carry_q;
  assign io.overflow  = overflow_q;
  assign io.zero      = zero_q;
  assign io.negative  = negative_q;
  assign io.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (WIDTH=8) with an in-order result scoreboard.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int WIDTH = 8;

  typedef struct {
    logic [7:0] res;
    logic       c;
    logic       v;
    logic       z;
    logic       n;
    logic       ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(WIDTH)) bus ();

  alu_pipe #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] r, input logic c, input logic v, input logic ill);
    exp_t e;
    e.res = r;
    e.c   = c;
    e.v   = v;
    e.ill = ill;
    e.z   = (r == 8'h00);
    e.n   = r[7];
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives one beat; leaves in_valid high so consecutive calls issue back-to-back.
  task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                               input logic expect_out, input exp_t e);
    int n = 0;
    if (!bus.in_ready) bus.in_valid = 1'b0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.in_ready) begin
      checkOutput("in_ready_timeout", {31'b0, bus.in_ready}, 1);
      return;
    end
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    if (expect_out) sb.push_back(e);
    tick();
  endtask

  task automatic waitValid(input string tag);
    int n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    checkOutput(tag, {31'b0, bus.out_valid}, 1);
  endtask

  // Every result handed to the consumer is matched against the oldest expected entry.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_result", {31'b0, bus.out_valid}, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("sb_result",   {24'b0, bus.result},   {24'b0, e.res});
        checkOutput("sb_carry",    {31'b0, bus.carry},    {31'b0, e.c});
        checkOutput("sb_overflow", {31'b0, bus.overflow}, {31'b0, e.v});
        checkOutput("sb_zero",     {31'b0, bus.zero},     {31'b0, e.z});
        checkOutput("sb_negative", {31'b0, bus.negative}, {31'b0, e.n});
        checkOutput("sb_illegal",  {31'b0, bus.illegal},  {31'b0, e.ill});
      end
    end
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = '0;
    tick();
    tick();
    checkOutput("rst_in_ready",  {31'b0, bus.in_ready},  0);
    checkOutput("rst_out_valid", {31'b0, bus.out_valid}, 0);
    checkOutput("rst_result",    {24'b0, bus.result},    0);
    checkOutput("rst_flags", {27'b0, bus.carry, bus.overflow, bus.zero, bus.negative, bus.illegal}, 0);
    rst = 1'b0;
    #1;
    checkOutput("in_ready_after_rst", {31'b0, bus.in_ready}, 1);

    $display("[TB] single-cycle ops, back-to-back");
    applyStimulus(OP_ADD, 8'hF0, 8'h20, 1'b1, mk(8'h10, 1'b1, 1'b0, 1'b0));
    checkOutput("add_latency", {31'b0, bus.out_valid}, 1);
    applyStimulus(OP_ADD, 8'h7F, 8'h01, 1'b1, mk(8'h80, 1'b0, 1'b1, 1'b0));
    applyStimulus(OP_SUB, 8'h03, 8'h05, 1'b1, mk(8'hFE, 1'b1, 1'b0, 1'b0));
    applyStimulus(OP_SUB, 8'h80, 8'h01, 1'b1, mk(8'h7F, 1'b0, 1'b1, 1'b0));
    checkOutput("b2b_in_ready", {31'b0, bus.in_ready}, 1);
    applyStimulus(OP_SHR, 8'h81, 8'h01, 1'b1, mk(8'h40, 1'b1, 1'b0, 1'b0));
    applyStimulus(OP_SRA, 8'h81, 8'h01, 1'b1, mk(8'hC0, 1'b1, 1'b0, 1'b0));
    applyStimulus(OP_SHL, 8'h81, 8'h00, 1'b1, mk(8'h81, 1'b0, 1'b0, 1'b0));
    applyStimulus(OP_SHL, 8'h81, 8'h01, 1'b1, mk(8'h02, 1'b1, 1'b0, 1'b0));
    applyStimulus(OP_AND, 8'hF0, 8'h3C, 1'b1, mk(8'h30, 1'b0, 1'b0, 1'b0));
    applyStimulus(OP_OR,  8'hF0, 8'h0F, 1'b1, mk(8'hFF, 1'b0, 1'b0, 1'b0));
    applyStimulus(OP_NOT, 8'h0F, 8'h00, 1'b1, mk(8'hF0, 1'b0, 1'b0, 1'b0));
    applyStimulus(OP_XOR, 8'hAA, 8'hAA, 1'b1, mk(8'h00, 1'b0, 1'b0, 1'b0));
    checkOutput("b2b_out_valid", {31'b0, bus.out_valid}, 1);
    bus.in_valid = 1'b0;
    tick();
    checkOutput("drain_out_valid", {31'b0, bus.out_valid}, 0);

    $display("[TB] multiply timing");
    applyStimulus(OP_MUL, 8'h0F, 8'h11, 1'b1, mk(8'hFF, 1'b0, 1'b0, 1'b0));
    bus.in_valid = 1'b0;
    for (int i = 1; i <= WIDTH; i++) begin
      checkOutput($sformatf("mul_busy_ready_%0d", i), {31'b0, bus.in_ready}, 0);
      checkOutput($sformatf("mul_busy_valid_%0d", i), {31'b0, bus.out_valid}, 0);
      tick();
    end
    checkOutput("mul_done_at_width", {31'b0, bus.out_valid}, 1);
    applyStimulus(OP_MUL, 8'h10, 8'h10, 1'b1, mk(8'h00, 1'b1, 1'b1, 1'b0));
    bus.in_valid = 1'b0;
    waitValid("mul2_done");
    tick();

    $display("[TB] backpressure");
    bus.out_ready = 1'b0;
    applyStimulus(OP_ADD, 8'h12, 8'h34, 1'b1, mk(8'h46, 1'b0, 1'b0, 1'b0));
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("hold_valid",    {31'b0, bus.out_valid}, 1);
      checkOutput("hold_result",   {24'b0, bus.result},    32'h46);
      checkOutput("hold_in_ready", {31'b0, bus.in_ready},  0);
      tick();
    end
    bus.out_ready = 1'b1;
    bus.op        = OP_XOR;
    bus.a         = 8'h0F;
    bus.b         = 8'hFF;
    bus.in_valid  = 1'b1;
    #1;
    checkOutput("drain_accept_ready", {31'b0, bus.in_ready}, 1);
    sb.push_back(mk(8'hF0, 1'b0, 1'b0, 1'b0));
    tick();
    checkOutput("drain_accept_valid", {31'b0, bus.out_valid}, 1);

    $display("[TB] illegal opcode");
    applyStimulus(4'b1100, 8'h55, 8'hAA, 1'b1, mk(8'h00, 1'b0, 1'b0, 1'b1));
    bus.in_valid = 1'b0;
    tick();

    $display("[TB] reset during multiply");
    applyStimulus(OP_MUL, 8'h03, 8'h05, 1'b0, mk(8'h0F, 1'b0, 1'b0, 1'b0));
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    checkOutput("rst_comb_in_ready", {31'b0, bus.in_ready}, 0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("abort_out_valid", {31'b0, bus.out_valid}, 0);
    checkOutput("abort_in_ready",  {31'b0, bus.in_ready},  1);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("abort_no_result", {31'b0, bus.out_valid}, 0);
    end
    applyStimulus(OP_ADD, 8'h01, 8'h01, 1'b1, mk(8'h02, 1'b0, 1'b0, 1'b0));
    bus.in_valid = 1'b0;
    waitValid("post_abort_add");
    tick();
    tick();

    checkOutput("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
